// File: rtl/audio_pkg.sv
// Shared audio types: default sample width, sample-buffer FSM states and
// the stereo pair layout used on the engine-to-I2S path.
package audio_pkg;

  localparam int DEFAULT_SAMPLE_W = 16;

  typedef enum logic {
    PRIME,
    RUN
  } buf_state_t;

  typedef struct packed {
    logic [DEFAULT_SAMPLE_W-1:0] left;
    logic [DEFAULT_SAMPLE_W-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/audio_fifo.sv
// Generic synchronous FIFO with occupancy count; pushes while full and pops
// while empty are ignored. The head entry is always visible on rdata_o.
module audio_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage has no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/i2s_sample_buffer.sv
// Stereo sample buffer feeding the I2S controller: one pair per frame_clk rise,
// muted until half full, falls back to priming on underrun.
module i2s_sample_buffer
  import audio_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SAMPLE_W = DEFAULT_SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SAMPLE_W-1:0]      in_left,
  input  logic [SAMPLE_W-1:0]      in_right,
  input  logic                     frame_clk,
  output logic [SAMPLE_W-1:0]      sample_left,
  output logic [SAMPLE_W-1:0]      sample_right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  output logic [7:0]               underrun_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int PW = 2 * SAMPLE_W;

  logic                sync1_q, sync2_q, sync3_q;
  logic                tick;
  buf_state_t          state_q;
  logic [SAMPLE_W-1:0] left_q, right_q;
  logic                underrun_q;
  logic [7:0]          count_q, count_d;
  logic                full, empty, push, pop;
  logic [PW-1:0]       head;

  audio_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_left, in_right}),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // frame_clk is from another timing domain as far as this block is concerned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= frame_clk;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign tick    = sync2_q & ~sync3_q;
  assign push    = in_valid & ~full;
  assign pop     = (state_q == RUN) & tick & ~empty;
  assign count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PRIME;
      left_q     <= '0;
      right_q    <= '0;
      underrun_q <= 1'b0;
      count_q    <= '0;
    end else begin
      underrun_q <= 1'b0;
      case (state_q)
        PRIME: begin
          if (tick) begin
            left_q  <= '0;
            right_q <= '0;
          end
          if (level >= LW'(DEPTH / 2)) state_q <= RUN;
        end
        RUN: begin
          if (tick) begin
            if (!empty) begin
              {left_q, right_q} <= head;
            end else begin
              left_q     <= '0;
              right_q    <= '0;
              underrun_q <= 1'b1;
              count_q    <= count_d;
              state_q    <= PRIME;
            end
          end
        end
      endcase
    end
  end

  assign in_ready       = ~full;
  assign sample_left    = left_q;
  assign sample_right   = right_q;
  assign underrun       = underrun_q;
  assign underrun_count = count_q;

endmodule
